// File: rtl/pulse_blink_stretcher.sv
// Stretches one-cycle event pulses into visible LED blinks (ON_CYCLES high, OFF_CYCLES low).
// Pulses that arrive during a blink are queued and replayed back-to-back.
module pulse_blink_stretcher #(
  parameter int unsigned ON_CYCLES  = 250000,
  parameter int unsigned OFF_CYCLES = 250000,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pulse_i,
  output logic              led_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               led_d, busy_d, overflow_d;
  logic [PEND_W-1:0]  pending_d;
  logic               start, take;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      led_o      <= 1'b0;
      busy_o     <= 1'b0;
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      led_o      <= led_d;
      busy_o     <= busy_d;
      pending_o  <= pending_d;
      overflow_o <= overflow_d;
    end
  end

  // Next-state, phase counter and pending queue
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    led_d      = led_o;
    pending_d  = pending_o;
    overflow_d = overflow_o;
    take       = 1'b0;
    start      = pulse_i | (pending_o != '0);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ON;
          count_d = '0;
          led_d   = 1'b1;
          take    = 1'b1;
        end
      end
      ST_ON: begin
        if (count_q == ON_LAST) begin
          state_d = ST_OFF;
          count_d = '0;
          led_d   = 1'b0;
        end else begin
          count_d = count_q + CNT_W'(1);
          led_d   = 1'b1;
        end
      end
      ST_OFF: begin
        if (count_q == OFF_LAST) begin
          count_d = '0;
          if (start) begin
            state_d = ST_ON;
            led_d   = 1'b1;
            take    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        led_d   = 1'b0;
      end
    endcase

    // A start either consumes the live pulse or one queued entry (re-queuing a coincident pulse)
    if (take) begin
      if ((pending_o != '0) && !pulse_i) begin
        pending_d = pending_o - PEND_W'(1);
      end
    end else if (pulse_i) begin
      if (pending_o == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_o + PEND_W'(1);
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_pulse_blink_stretcher.sv
// Scoreboard bench for pulse_blink_stretcher: a countdown reference model queues expected
// outputs as each cycle is driven; they are popped and compared after the clock edge.
module tb_pulse_blink_stretcher;

  localparam int unsigned ON_C   = 4;
  localparam int unsigned OFF_C  = 3;
  localparam int unsigned PW     = 2;
  localparam int unsigned P_MAX  = (1 << PW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          pulse_i;
  logic          led_o;
  logic          busy_o;
  logic [PW-1:0] pending_o;
  logic          overflow_o;

  pulse_blink_stretcher #(
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .PEND_W    (PW)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .pulse_i   (pulse_i),
    .led_o     (led_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       led;
    logic       busy;
    int         pend;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // reference model state: phase 0=idle 1=on 2=off, left = cycles remaining in phase
  int   m_phase = 0;
  int   m_left  = 0;
  int   m_pend  = 0;
  logic m_ovf   = 1'b0;

  int   blinks    = 0;
  int   max_pend  = 0;
  int   busy_lows = 0;
  logic led_prev  = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic pulse, input logic rst);
    logic start;
    logic take;
    exp_t e;
    take = 1'b0;
    if (rst) begin
      m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
    end else begin
      start = pulse || (m_pend > 0);
      case (m_phase)
        0: if (start) begin m_phase = 1; m_left = ON_C; take = 1'b1; end
        1: begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_left = OFF_C; end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            if (start) begin m_phase = 1; m_left = ON_C; take = 1'b1; end
            else m_phase = 0;
          end
        end
      endcase
      if (take) begin
        if (m_pend > 0 && !pulse) m_pend--;
      end else if (pulse) begin
        if (m_pend == P_MAX) m_ovf = 1'b1;
        else m_pend++;
      end
    end
    e.led  = (m_phase == 1);
    e.busy = (m_phase != 0);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  // drive one cycle, queue its expectation, then compare after the edge
  task automatic cycle(input logic pulse, input logic rst);
    exp_t e;
    pulse_i = pulse;
    reset_i = rst;
    model_step(pulse, rst);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("led",      int'(led_o),      int'(e.led));
      check("busy",     int'(busy_o),     int'(e.busy));
      check("pending",  int'(pending_o),  e.pend);
      check("overflow", int'(overflow_o), int'(e.ovf));
    end
    if (led_o === 1'b1 && led_prev !== 1'b1) blinks++;
    led_prev = led_o;
    if (int'(pending_o) > max_pend) max_pend = int'(pending_o);
    if (busy_o !== 1'b1) busy_lows++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic clear_stats();
    blinks = 0; max_pend = 0; busy_lows = 0;
  endtask

  initial begin
    pulse_i = 1'b0;
    reset_i = 1'b1;

    // 1: reset
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("reset_led", int'(led_o), 0);
    check("reset_pending", int'(pending_o), 0);

    // 2: single pulse
    clear_stats();
    cycle(1'b1, 1'b0);
    check("single_led_rise", int'(led_o), 1);
    idle(12);
    check("single_blinks", blinks, 1);
    check("single_pending_max", max_pend, 0);
    check("single_busy_end", int'(busy_o), 0);

    // 3: queued pulses
    clear_stats();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("queued_pending3", int'(pending_o), 3);
    idle(30);
    check("queued_blinks", blinks, 4);
    check("queued_busy_end", int'(busy_o), 0);
    check("queued_no_ovf", int'(overflow_o), 0);

    // 4: overflow
    clear_stats();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    check("ovf_set", int'(overflow_o), 1);
    idle(32);
    check("ovf_blinks", blinks, 4);
    check("ovf_sticky", int'(overflow_o), 1);
    cycle(1'b0, 1'b1);
    check("ovf_reset_clear", int'(overflow_o), 0);

    // 5: pulse on the final OFF cycle chains with no idle gap
    clear_stats();
    cycle(1'b1, 1'b0);
    idle(6);
    cycle(1'b1, 1'b0);
    check("chain_led_rise", int'(led_o), 1);
    idle(6);
    check("chain_busy_never_low", busy_lows, 0);
    check("chain_pending_max", max_pend, 0);
    idle(4);
    check("chain_blinks", blinks, 2);

    // 6: reset mid-ON with two queued, then a normal blink
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("midon_pending2", int'(pending_o), 2);
    cycle(1'b1, 1'b1);
    check("midon_reset_led", int'(led_o), 0);
    check("midon_reset_pending", int'(pending_o), 0);
    check("midon_reset_busy", int'(busy_o), 0);
    clear_stats();
    cycle(1'b1, 1'b0);
    idle(10);
    check("post_reset_blinks", blinks, 1);

    // random stress against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 60) == 0));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
